scalar_io_fifo_port: RTL and testbench
======================================

# scalar_io_fifo_port

Responder-side I/O port for the Scalar core's memory-mapped A/B I/O ports: the device that sits on one `*_io_rden/_io_in` read port plus one `*_io_wren/_io_out` write port. Core writes are buffered into a TX FIFO drained by an external valid/ready consumer. An RX FIFO, filled by an external valid/ready producer, presents its head word to the core and pops on each core read. Octavo threads never stall, so empty reads and full writes complete anyway and are recorded in sticky error flags.

## Interface
- `WORD_WIDTH`, 36: data word width; must equal the core's A/B word width.
- `DEPTH`, 8: entries per FIFO; must be a power of two, minimum 2.
- `ADDR_WIDTH`, 3: log2(`DEPTH`).

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `io_rden` in 1: core read strobe from the core's `*_io_rden` bit; pops the RX head.
- `io_in` out `WORD_WIDTH`: RX head word; drives the core's `*_io_in` slice.
- `io_wren` in 1: core write strobe from the core's `*_io_wren` bit.
- `io_out` in `WORD_WIDTH`: core write data from the core's `*_io_out` slice.
- `rx_valid` in 1: external producer has a word.
- `rx_ready` out 1: RX FIFO can accept a word.
- `rx_data` in `WORD_WIDTH`: producer data.
- `tx_valid` out 1: TX FIFO holds a word.
- `tx_ready` in 1: consumer accepts the word.
- `tx_data` out `WORD_WIDTH`: TX head word.
- `rx_count` out `ADDR_WIDTH+1`: RX occupancy.
- `tx_count` out `ADDR_WIDTH+1`: TX occupancy.
- `status_clear` in 1: synchronous clear of the sticky flags.
- `underflow` out 1: sticky flag; set when the core read an empty RX FIFO.
- `overflow` out 1: sticky flag; set when the core wrote to a full TX FIFO.

## Operation
- Reset: both FIFOs empty and pointers 0.
  - `io_in`=0, `tx_data`=0, `tx_valid`=0, `rx_ready`=1, counts 0, `underflow`=`overflow`=0.
  - Storage contents are not reset.
- RX push:
  - `rx_valid & rx_ready` writes `rx_data` at the write pointer, increments the write pointer and `rx_count`.
  - `rx_ready` = (`rx_count` != `DEPTH`), derived from registered count only.
  - `rx_ready` never depends combinationally on `io_rden`.
- RX pop (first-word fall-through):
  - `io_in` = head word when `rx_count` > 0, else 0.
  - `io_rden` with `rx_count` > 0: read pointer +1, count −1.
  - `io_rden` with `rx_count` == 0: no pointer or count change; `underflow` set; `io_in` stays 0.
- TX push:
  - `io_wren` with `tx_count` < `DEPTH`: writes `io_out`, increments the write pointer and count.
  - `io_wren` with `tx_count` == `DEPTH`: word dropped, `overflow` set.
  - The full decision uses the start-of-cycle count even if a TX pop occurs in the same cycle.
- TX pop:
  - `tx_valid` = (`tx_count` != 0); `tx_data` = head word, or 0 when empty.
  - `tx_valid & tx_ready` advances the read pointer.
- Simultaneous push and pop on the same FIFO (both legal): count unchanged, both pointers advance.
- Pointers are `ADDR_WIDTH` bits and wrap modulo `DEPTH`. Counts saturate only by construction and never exceed `DEPTH`.
- Sticky flags:
  - `status_clear` clears them.
  - A set event in the same cycle as `status_clear` wins: the flag reads 1 next cycle.
- `tx_valid`, `tx_data`, `rx_ready` and `io_in` must not be combinational from `rx_valid`, `tx_ready`, `io_rden` or `io_wren`. This breaks paths into the core.

## Timing
- RX word accepted at edge N → visible on `io_in` after edge N, i.e. readable by the core in cycle N+1.
- Core read with `io_rden` in cycle N → next word on `io_in` in cycle N+1.
- Core write in cycle N → `tx_valid`/`tx_data` asserted in cycle N+1.
- Flags update one cycle after the offending strobe.
- Reset asserted mid-transfer: every output takes its reset value immediately (asynchronously). In-flight words are lost and flags are cleared.
- Reset deassertion is synchronised externally; the first push is legal on the first edge after deassertion.

## Structure
- Shared package constants: default `WORD_WIDTH`, `DEPTH`, `ADDR_WIDTH` for Octavo I/O ports.
- One natural sub-module, `fifo_fwft`: parameterised storage, pointers, count, and first-word-fall-through head. It is instantiated twice, once for RX and once for TX.
- `fifo_fwft` also serves other Octavo accelerator ports.
- Top level adds the sticky flags, the drop-on-full and empty-read rules, and the port mapping.
- The storage array uses the codebase RAMSTYLE parameter convention; it defaults to logic registers for small `DEPTH`.

## Test plan
- Reset, then push RX words 0x1, 0x2, 0x3 → `io_in`=0x1 one cycle after the first accept; three consecutive `io_rden` strobes return 0x1, 0x2, 0x3; `rx_count` goes to 0.
- Push 8 RX words with `DEPTH`=8 → `rx_ready`=0 and `rx_count`=8. Then do one `io_rden` and hold `rx_valid` → `rx_ready` returns to 1 next cycle and the 9th word is accepted.
- `io_rden` on empty RX → `io_in`=0, `underflow`=1 next cycle, pointers unchanged. Then pulse `status_clear` → `underflow`=0.
- With `tx_ready`=0, issue 9 core writes 0x10..0x18 → `tx_count`=8 and `overflow`=1. Then raise `tx_ready` → `tx_data` sequence is 0x10..0x17; 0x18 never appears.
- Simultaneous `io_wren` and `tx_valid & tx_ready` at `tx_count`=4 → count stays 4; order is preserved across pointer wrap after 20 such cycles.
- Assert `reset` while both FIFOs hold 3 words → outputs take reset values immediately. After release, `tx_valid`=0, `io_in`=0 and both counts are 0.

Source files
------------

// File: rtl/scalar_io_fifo_port_pkg.sv
// Shared defaults for Octavo memory-mapped A/B I/O port responders.
package scalar_io_fifo_port_pkg;

  localparam int    IO_WORD_WIDTH = 36;
  localparam int    IO_DEPTH      = 8;
  localparam int    IO_ADDR_WIDTH = 3;
  localparam string IO_RAMSTYLE   = "logic";

endpackage

// File: rtl/scalar_io_fifo_port_fifo_fwft.sv
// First-word-fall-through FIFO: registered pointers and count, head word
// visible combinationally from storage, zero when empty.
module fifo_fwft #(
  parameter int    WORD_WIDTH = 36,
  parameter int    DEPTH      = 8,
  parameter int    ADDR_WIDTH = 3,
  parameter string RAMSTYLE   = "logic"
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WORD_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [WORD_WIDTH-1:0] head_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;
  logic [WORD_WIDTH-1:0] head_word;

  // Full/empty come from the start-of-cycle count, so a same-cycle pop never
  // makes room for a push into a full FIFO.
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; only the pointers define which entries are live.
  generate
    if (RAMSTYLE == "logic") begin : g_regs
      (* ramstyle = "logic" *) logic [WORD_WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
      end
      assign head_word = mem[rd_ptr];
    end else begin : g_ram
      (* ramstyle = RAMSTYLE *) logic [WORD_WIDTH-1:0] mem [DEPTH];
      always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
      end
      assign head_word = mem[rd_ptr];
    end
  endgenerate

  assign head_data = empty ? '0 : head_word;

endmodule

// File: rtl/scalar_io_fifo_port.sv
// Responder-side Scalar core I/O port: core writes feed a TX FIFO, core reads
// pop an RX FIFO; empty reads and full writes complete and set sticky flags.
module scalar_io_fifo_port
  import scalar_io_fifo_port_pkg::*;
#(
  parameter int    WORD_WIDTH = IO_WORD_WIDTH,
  parameter int    DEPTH      = IO_DEPTH,
  parameter int    ADDR_WIDTH = IO_ADDR_WIDTH,
  parameter string RAMSTYLE   = IO_RAMSTYLE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_rden,
  output logic [WORD_WIDTH-1:0] io_in,
  input  logic                  io_wren,
  input  logic [WORD_WIDTH-1:0] io_out,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [WORD_WIDTH-1:0] rx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [WORD_WIDTH-1:0] tx_data,
  output logic [ADDR_WIDTH:0]   rx_count,
  output logic [ADDR_WIDTH:0]   tx_count,
  input  logic                  status_clear,
  output logic                  underflow,
  output logic                  overflow
);

  logic rx_empty;
  logic rx_full;
  logic tx_empty;
  logic tx_full;

  fifo_fwft #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAMSTYLE   (RAMSTYLE)
  ) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (io_rden),
    .head_data (io_in),
    .count     (rx_count),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  fifo_fwft #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAMSTYLE   (RAMSTYLE)
  ) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (io_wren),
    .push_data (io_out),
    .pop       (tx_ready),
    .head_data (tx_data),
    .count     (tx_count),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  assign rx_ready = ~rx_full;
  assign tx_valid = ~tx_empty;

  // A new error event outranks a simultaneous clear so it is never lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (io_rden && rx_empty)  underflow <= 1'b1;
      else if (status_clear)    underflow <= 1'b0;
      if (io_wren && tx_full)   overflow  <= 1'b1;
      else if (status_clear)    overflow  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scalar_io_fifo_port.sv
// Directed self-checking bench for scalar_io_fifo_port with hand-computed
// expectations for the RX/TX FIFOs, sticky flags and asynchronous reset.
module tb_scalar_io_fifo_port;

  localparam int W = 36;
  localparam int A = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic         io_rden;
  logic [W-1:0] io_in;
  logic         io_wren;
  logic [W-1:0] io_out;
  logic         rx_valid;
  logic         rx_ready;
  logic [W-1:0] rx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] tx_data;
  logic [A:0]   rx_count;
  logic [A:0]   tx_count;
  logic         status_clear;
  logic         underflow;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  scalar_io_fifo_port dut (
    .clock        (clock),
    .reset        (reset),
    .io_rden      (io_rden),
    .io_in        (io_in),
    .io_wren      (io_wren),
    .io_out       (io_out),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .rx_count     (rx_count),
    .tx_count     (tx_count),
    .status_clear (status_clear),
    .underflow    (underflow),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1; io_rden = 0; io_wren = 0; io_out = '0; rx_valid = 0;
    rx_data = '0; tx_ready = 0; status_clear = 0;
    step(); step();
    check_output("reset_io_in", io_in, 0);
    check_output("reset_tx_valid", tx_valid, 0);
    check_output("reset_tx_data", tx_data, 0);
    check_output("reset_rx_ready", rx_ready, 1);
    check_output("reset_rx_count", rx_count, 0);
    check_output("reset_tx_count", tx_count, 0);
    check_output("reset_flags", {underflow, overflow}, 0);
    reset = 1'b0;

    // RX: push 1,2,3 then read them back in order.
    rx_valid = 1; rx_data = 36'h1; step();
    check_output("rx_fwft_first", io_in, 36'h1);
    check_output("rx_count_1", rx_count, 1);
    rx_data = 36'h2; step();
    rx_data = 36'h3; step();
    rx_valid = 0;
    check_output("rx_count_3", rx_count, 3);
    io_rden = 1;
    check_output("rx_read_1", io_in, 36'h1); step();
    check_output("rx_read_2", io_in, 36'h2); step();
    check_output("rx_read_3", io_in, 36'h3); step();
    io_rden = 0;
    check_output("rx_drained_count", rx_count, 0);
    check_output("rx_drained_io_in", io_in, 0);
    check_output("rx_no_underflow", underflow, 0);

    // RX full, then one read frees a slot for the held 9th word.
    rx_valid = 1;
    for (int i = 0; i < 8; i++) begin
      rx_data = W'(32'h20 + i);
      step();
    end
    check_output("rx_full_ready", rx_ready, 0);
    check_output("rx_full_count", rx_count, 8);
    rx_data = 36'h28; io_rden = 1;
    check_output("rx_full_head", io_in, 36'h20);
    step();
    io_rden = 0;
    check_output("rx_ready_back", rx_ready, 1);
    check_output("rx_count_7", rx_count, 7);
    step();
    rx_valid = 0;
    check_output("rx_9th_count", rx_count, 8);
    io_rden = 1;
    for (int i = 1; i <= 8; i++) begin
      check_output("rx_full_drain", io_in, W'(32'h20 + i));
      step();
    end
    io_rden = 0;
    check_output("rx_full_drained", rx_count, 0);

    // Underflow on empty read, clear, then pointers still intact.
    io_rden = 1;
    check_output("underflow_io_in", io_in, 0);
    step();
    io_rden = 0;
    check_output("underflow_set", underflow, 1);
    check_output("underflow_io_in_after", io_in, 0);
    check_output("underflow_count", rx_count, 0);
    status_clear = 1; step(); status_clear = 0;
    check_output("underflow_cleared", underflow, 0);
    rx_valid = 1; rx_data = 36'h55; step(); rx_valid = 0;
    check_output("rx_after_underflow", io_in, 36'h55);
    io_rden = 1; step(); io_rden = 0;
    check_output("rx_after_underflow_count", rx_count, 0);
    io_rden = 1; status_clear = 1; step(); io_rden = 0;
    check_output("set_beats_clear", underflow, 1);
    step(); status_clear = 0;
    check_output("clear_after_set", underflow, 0);

    // TX overflow: 9 writes into 8 slots, last word dropped.
    tx_ready = 0; io_wren = 1;
    for (int i = 0; i < 9; i++) begin
      io_out = W'(32'h10 + i);
      step();
    end
    io_wren = 0;
    check_output("tx_full_count", tx_count, 8);
    check_output("overflow_set", overflow, 1);
    check_output("tx_valid_full", tx_valid, 1);
    tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check_output("tx_drain", tx_data, W'(32'h10 + i));
      step();
    end
    tx_ready = 0;
    check_output("tx_empty_valid", tx_valid, 0);
    check_output("tx_empty_data", tx_data, 0);
    check_output("tx_empty_count", tx_count, 0);
    status_clear = 1; step(); status_clear = 0;
    check_output("overflow_cleared", overflow, 0);

    // TX simultaneous push/pop at count 4 across pointer wrap.
    io_wren = 1;
    for (int i = 0; i < 4; i++) begin
      io_out = W'(32'h30 + i);
      step();
    end
    tx_ready = 1;
    for (int i = 0; i < 20; i++) begin
      io_out = W'(32'h34 + i);
      check_output("tx_stream_data", tx_data, W'(32'h30 + i));
      step();
      check_output("tx_stream_count", tx_count, 4);
    end
    io_wren = 0;
    for (int i = 20; i < 24; i++) begin
      check_output("tx_stream_tail", tx_data, W'(32'h30 + i));
      step();
    end
    tx_ready = 0;
    check_output("tx_stream_empty", tx_count, 0);
    check_output("tx_stream_no_overflow", overflow, 0);

    // Asynchronous reset with both FIFOs holding 3 words and a flag set.
    io_rden = 1; step(); io_rden = 0;
    rx_valid = 1; io_wren = 1;
    for (int i = 0; i < 3; i++) begin
      rx_data = W'(32'h41 + i);
      io_out  = W'(32'h51 + i);
      step();
    end
    rx_valid = 0; io_wren = 0;
    check_output("pre_reset_counts", {rx_count, tx_count}, {4'd3, 4'd3});
    check_output("pre_reset_underflow", underflow, 1);
    #2 reset = 1'b1;
    #1;
    check_output("async_io_in", io_in, 0);
    check_output("async_tx_valid", tx_valid, 0);
    check_output("async_tx_data", tx_data, 0);
    check_output("async_rx_ready", rx_ready, 1);
    check_output("async_counts", {rx_count, tx_count}, 0);
    check_output("async_flags", {underflow, overflow}, 0);
    step();
    reset = 1'b0;
    step();
    check_output("post_reset_tx_valid", tx_valid, 0);
    check_output("post_reset_io_in", io_in, 0);
    check_output("post_reset_counts", {rx_count, tx_count}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
